// File: rtl/program_loader.sv
// rtl/program_loader.sv - host byte-stream loader into CPU instruction memory
// Length byte, then L payload bytes written one per transfer, then a short CPU reset hold before release.
module program_loader #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ins_write,
  output logic       ins_read,
  output logic [7:0] instruction_write_data,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] load_count
);

  typedef enum logic [1:0] {IDLE, LEN, LOAD, BOOT} state_t;

  state_t     state, state_nx;
  logic [7:0] len_q, len_nx;
  logic [7:0] idle_cnt, idle_nx;
  logic       boot_cnt, boot_nx;

  logic       byte_ready_nx, ins_write_nx, cpu_reset_nx, done_nx, error_nx;
  logic [7:0] data_nx, count_nx;

  logic       xfer;
  logic       idle_expired;
  logic       last_byte;

  assign xfer = byte_valid && byte_ready;
  // Fires on the non-transfer cycle that would bring the idle count up to TIMEOUT.
  assign idle_expired = ({1'b0, idle_cnt} + 9'd1) >= {1'b0, TIMEOUT};
  assign last_byte = ({1'b0, load_count} + 9'd1) == {1'b0, len_q};
  assign busy = (state != IDLE);

  always_comb begin
    state_nx      = state;
    len_nx        = len_q;
    idle_nx       = idle_cnt;
    boot_nx       = boot_cnt;
    byte_ready_nx = 1'b0;
    ins_write_nx  = 1'b0;
    data_nx       = instruction_write_data;
    cpu_reset_nx  = cpu_reset;
    done_nx       = done;
    error_nx      = error;
    count_nx      = load_count;

    case (state)
      IDLE: begin
        if (start) begin
          done_nx       = 1'b0;
          error_nx      = 1'b0;
          count_nx      = 8'd0;
          cpu_reset_nx  = 1'b1;
          idle_nx       = 8'd0;
          byte_ready_nx = 1'b1;
          state_nx      = LEN;
        end
      end

      LEN: begin
        byte_ready_nx = 1'b1;
        if (xfer) begin
          len_nx  = byte_in;
          idle_nx = 8'd0;
          if (byte_in == 8'd0) begin
            error_nx      = 1'b1;
            cpu_reset_nx  = 1'b0;
            byte_ready_nx = 1'b0;
            state_nx      = IDLE;
          end else begin
            state_nx = LOAD;
          end
        end else if (idle_expired) begin
          error_nx      = 1'b1;
          cpu_reset_nx  = 1'b0;
          byte_ready_nx = 1'b0;
          idle_nx       = 8'd0;
          state_nx      = IDLE;
        end else begin
          idle_nx = idle_cnt + 8'd1;
        end
      end

      LOAD: begin
        byte_ready_nx = 1'b1;
        if (xfer) begin
          ins_write_nx = 1'b1;
          data_nx      = byte_in;
          idle_nx      = 8'd0;
          if (load_count != 8'hFF) begin
            count_nx = load_count + 8'd1;
          end
          if (last_byte) begin
            byte_ready_nx = 1'b0;
            boot_nx       = 1'b0;
            state_nx      = BOOT;
          end
        end else if (idle_expired) begin
          error_nx      = 1'b1;
          cpu_reset_nx  = 1'b0;
          byte_ready_nx = 1'b0;
          idle_nx       = 8'd0;
          state_nx      = IDLE;
        end else begin
          idle_nx = idle_cnt + 8'd1;
        end
      end

      BOOT: begin
        // cpu_reset stays high for two BOOT cycles, released together with done.
        if (boot_cnt) begin
          cpu_reset_nx = 1'b0;
          done_nx      = 1'b1;
          boot_nx      = 1'b0;
          state_nx     = IDLE;
        end else begin
          boot_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      len_q                  <= 8'd0;
      idle_cnt               <= 8'd0;
      boot_cnt               <= 1'b0;
      byte_ready             <= 1'b0;
      ins_write              <= 1'b0;
      ins_read               <= 1'b1;
      instruction_write_data <= 8'h00;
      cpu_reset              <= 1'b0;
      done                   <= 1'b0;
      error                  <= 1'b0;
      load_count             <= 8'd0;
    end else begin
      state                  <= state_nx;
      len_q                  <= len_nx;
      idle_cnt               <= idle_nx;
      boot_cnt               <= boot_nx;
      byte_ready             <= byte_ready_nx;
      ins_write              <= ins_write_nx;
      ins_read               <= ~ins_write_nx;
      instruction_write_data <= data_nx;
      cpu_reset              <= cpu_reset_nx;
      done                   <= done_nx;
      error                  <= error_nx;
      load_count             <= count_nx;
    end
  end

endmodule
